// File: rtl/trace_pkg.sv
// Shared definitions for the data-memory write tracer: timer and signature
// widths, record width helper, index-width helpers and the signature step.
package trace_pkg;

  localparam int TIMER_W = 32;
  localparam int SIG_W   = 32;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of an index selecting one of n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // Packed record: {win, off, data, strb, time}.
  function automatic int rec_w(input int win_w, input int off_w, input int data_w);
    return win_w + off_w + data_w + data_w / 8 + TIMER_W;
  endfunction

  // Rotate-left-by-one then fold in the store data and word offset.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] s,
                                                input logic [SIG_W-1:0] d,
                                                input logic [SIG_W-1:0] o);
    return {s[SIG_W-2:0], s[SIG_W-1]} ^ d ^ o;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO. A push into a full FIFO
// is accepted only when a pop happens at the same edge. The output word is
// forced to zero while empty so an idle port shows a clean payload.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count == '0);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Occupancy after this edge, used to register the full flag.
  always_comb begin
    count_next = count;
    if (push_en && !pop_en) count_next = count + (AW+1)'(1);
    if (!push_en && pop_en) count_next = count - (AW+1)'(1);
  end

  // Pointers, occupancy and full flag.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  // Storage array; contents need no reset since empty masks the output.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_write_tracer.sv
// Snoops the data-memory store port, matches stores against NUM_WIN word
// windows (lowest index wins), queues timestamped records in a FWFT FIFO and
// keeps saturating per-window hit counters and a drop counter.
// Optional feature macro: TRACE_SIG_EN adds per-window write signatures.
module dmem_write_tracer
  import trace_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WIN    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic [NUM_WIN*(ADDR_WIDTH-2)-1:0] win_base,
  input  logic [NUM_WIN*(ADDR_WIDTH-2)-1:0] win_words,
  input  logic                             mem_we,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH/8-1:0]          mem_wstrb,
  output logic                             trc_valid,
  input  logic                             trc_ready,
  output logic [idx_w(NUM_WIN)-1:0]        trc_win,
  output logic [ADDR_WIDTH-3:0]            trc_off,
  output logic [DATA_WIDTH-1:0]            trc_data,
  output logic [DATA_WIDTH/8-1:0]          trc_strb,
  output logic [TIMER_W-1:0]               trc_time,
  output logic [NUM_WIN*CNT_WIDTH-1:0]     hit_cnt,
  output logic [CNT_WIDTH-1:0]             drop_cnt
`ifdef TRACE_SIG_EN
  ,
  output logic [NUM_WIN*SIG_W-1:0]         sig
`endif
);

  localparam int WA_W   = ADDR_WIDTH - 2;
  localparam int WIN_W  = idx_w(NUM_WIN);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int REC_W  = rec_w(WIN_W, WA_W, DATA_WIDTH);

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic [WA_W-1:0]      wa;
  logic                 unused_addr_lsb;
  logic [WA_W-1:0]      diff [NUM_WIN];
  logic [NUM_WIN-1:0]   in_win;
  logic                 hit;
  logic [WIN_W-1:0]     hit_idx;
  logic [WA_W-1:0]      hit_off;
  logic                 capture;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 drop;
  logic [REC_W-1:0]     rec_in;
  logic [REC_W-1:0]     rec_out;
  logic [TIMER_W-1:0]   timer;
  logic [CNT_WIDTH-1:0] hits [NUM_WIN];

  assign wa              = mem_addr[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^mem_addr[1:0];

  // Unsigned modular distance handles windows that wrap the address space.
  for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
    assign diff[k]   = wa - win_base[k*WA_W +: WA_W];
    assign in_win[k] = (diff[k] < win_words[k*WA_W +: WA_W]);
    assign hit_cnt[k*CNT_WIDTH +: CNT_WIDTH] = hits[k];
  end

  // Priority select: scanning downward leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_off = '0;
    for (int k = NUM_WIN - 1; k >= 0; k--) begin
      if (in_win[k]) begin
        hit     = 1'b1;
        hit_idx = WIN_W'(k);
        hit_off = diff[k];
      end
    end
  end

  assign capture   = mem_we & hit & ~clr;
  assign drop      = capture & fifo_full & ~(trc_valid & trc_ready);
  assign rec_in    = {hit_idx, hit_off, mem_wdata, mem_wstrb, timer};
  assign trc_valid = ~fifo_empty;
  assign {trc_win, trc_off, trc_data, trc_strb, trc_time} = rec_out;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (capture),
    .din   (rec_in),
    .full  (fifo_full),
    .pop   (trc_ready),
    .empty (fifo_empty),
    .dout  (rec_out)
  );

  // Free-running cycle stamp, restarted by reset and clear.
  always_ff @(posedge clk) begin
    if (rst || clr) timer <= '0;
    else            timer <= timer + TIMER_W'(1);
  end

  // Per-window hit counters count every capture, dropped or not.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < NUM_WIN; k++) hits[k] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_WIN; k++) begin
        if (capture && hit_idx == WIN_W'(k)) hits[k] <= sat_inc(hits[k]);
      end
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

`ifdef TRACE_SIG_EN
  logic [SIG_W-1:0] sig_r [NUM_WIN];
  logic [SIG_W-1:0] data32;
  logic [SIG_W-1:0] off32;

  assign data32 = SIG_W'(mem_wdata);
  assign off32  = SIG_W'(hit_off);

  for (genvar k = 0; k < NUM_WIN; k++) begin : g_sig
    assign sig[k*SIG_W +: SIG_W] = sig_r[k];
  end

  // Signature folds every capture into its window, including dropped ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < NUM_WIN; k++) sig_r[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_WIN; k++) begin
        if (capture && hit_idx == WIN_W'(k)) sig_r[k] <= sig_step(sig_r[k], data32, off32);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_write_tracer.sv
// Self-checking bench for dmem_write_tracer: a reference model pushes the
// expected records into a scoreboard queue as stores are driven and pops them
// as the DUT hands records out. Counters are narrowed to 6 bits so that
// saturation is reachable in a short run.
module tb_dmem_write_tracer;

  localparam int CW    = 6;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [0:0]  win;
    logic [29:0] off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] tm;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, mem_we, trc_ready;
  logic [29:0] base [2];
  logic [29:0] words [2];
  logic [59:0] win_base, win_words;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        trc_valid;
  logic [0:0]  trc_win;
  logic [29:0] trc_off;
  logic [31:0] trc_data;
  logic [3:0]  trc_strb;
  logic [31:0] trc_time;
  logic [2*CW-1:0] hit_cnt;
  logic [CW-1:0]   drop_cnt;
`ifdef TRACE_SIG_EN
  logic [63:0] sig;
`endif

  assign win_base  = {base[1], base[0]};
  assign win_words = {words[1], words[0]};

  dmem_write_tracer #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .NUM_WIN (2),
    .FIFO_DEPTH (DEPTH), .CNT_WIDTH (CW)
  ) dut (
    .clk (clk), .rst (rst), .clr (clr),
    .win_base (win_base), .win_words (win_words),
    .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_wstrb (mem_wstrb),
    .trc_valid (trc_valid), .trc_ready (trc_ready),
    .trc_win (trc_win), .trc_off (trc_off), .trc_data (trc_data),
    .trc_strb (trc_strb), .trc_time (trc_time),
    .hit_cnt (hit_cnt), .drop_cnt (drop_cnt)
`ifdef TRACE_SIG_EN
    , .sig (sig)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  rec_t        exp_q [$];
  logic [31:0] m_time;
  logic [CW-1:0] m_hit [2];
  logic [CW-1:0] m_drop;
  logic [31:0] m_sig [2];
  bit          chk_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit0"}, hit_cnt[CW-1:0], m_hit[0]);
    chk({tag, "_hit1"}, hit_cnt[2*CW-1:CW], m_hit[1]);
    chk({tag, "_drop"}, drop_cnt, m_drop);
`ifdef TRACE_SIG_EN
    chk({tag, "_sig0"}, sig[31:0], m_sig[0]);
    chk({tag, "_sig1"}, sig[63:32], m_sig[1]);
`endif
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_time = '0;
    m_drop = '0;
    for (int i = 0; i < 2; i++) begin
      m_hit[i] = '0;
      m_sig[i] = '0;
    end
  endtask

  // One clock: check/consume the offered record, update the model with the
  // inputs currently driven, then advance past the edge.
  task automatic tick();
    rec_t        r;
    logic [29:0] wa, d, off;
    bit          h;
    int          k;
    if (chk_on) begin
      chk("valid", trc_valid, exp_q.size() != 0);
      if (exp_q.size() != 0 && trc_ready) begin
        r = exp_q.pop_front();
        chk("rec_win", trc_win, r.win);
        chk("rec_off", trc_off, r.off);
        chk("rec_data", trc_data, r.data);
        chk("rec_strb", trc_strb, r.strb);
        chk("rec_time", trc_time, r.tm);
      end
    end
    if (rst || clr) begin
      model_clear();
    end else begin
      if (mem_we) begin
        wa = mem_addr[31:2];
        h = 1'b0; k = 0; off = '0;
        for (int i = 0; i < 2; i++) begin
          d = wa - base[i];
          if (!h && d < words[i]) begin
            h = 1'b1; k = i; off = d;
          end
        end
        if (h) begin
          if (m_hit[k] != '1) m_hit[k]++;
          m_sig[k] = {m_sig[k][30:0], m_sig[k][31]} ^ mem_wdata ^ {2'b00, off};
          if (exp_q.size() < DEPTH) begin
            r.win = 1'(k); r.off = off; r.data = mem_wdata; r.strb = mem_wstrb; r.tm = m_time;
            exp_q.push_back(r);
          end else if (m_drop != '1) begin
            m_drop++;
          end
        end
      end
      m_time++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic drain(input string tag);
    trc_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
    chk({tag, "_drained"}, trc_valid, 1'b0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; mem_we = 1'b0; trc_ready = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    base[0] = '0; base[1] = '0; words[0] = '0; words[1] = '0;
    tick(); tick();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_valid", trc_valid, 1'b0);
    chk("rst_data", trc_data, 32'h0);
    chk("rst_time", trc_time, 32'h0);
    chk("rst_off", {trc_win, trc_off, trc_strb}, 35'h0);
    chk_cnt("rst");

    // Basic capture.
    trc_ready = 1'b1;
    base[0] = 30'h60; words[0] = 30'd32;
    put(32'h184, 32'hDEADBEEF, 4'hF);
    chk("s1_win", trc_win, 1'b0);
    chk("s1_off", trc_off, 30'h1);
    chk("s1_data", trc_data, 32'hDEADBEEF);
    chk("s1_strb", trc_strb, 4'hF);
    chk("s1_hit0", hit_cnt[CW-1:0], 6'd1);
    tick();

    // Overlapping windows: lowest index wins.
    base[1] = 30'h70; words[1] = 30'd16;
    put(32'h1D4, 32'h12345678, 4'h3);
    chk("s2_win", trc_win, 1'b0);
    chk("s2_off", trc_off, 30'h15);
    chk("s2_hit1", hit_cnt[2*CW-1:CW], 6'd0);
    tick();
    chk_cnt("s2");

    // Overflow with the consumer stalled.
    pulse_clr();
    trc_ready = 1'b0;
    for (int i = 0; i < 17; i++) put(32'h180 + 32'(4 * i), $urandom, 4'(i));
    chk("s3_drop", drop_cnt, 6'd1);
    chk("s3_hit0", hit_cnt[CW-1:0], 6'd17);
    chk_cnt("s3");

    // Full FIFO with a pop in the same cycle accepts the push.
    trc_ready = 1'b1;
    put(32'h188, 32'hCAFE0001, 4'hF);
    chk("s4_nodrop", drop_cnt, 6'd1);
    trc_ready = 1'b0;
    put(32'h18C, 32'hCAFE0002, 4'hF);
    chk("s4_still_full", drop_cnt, 6'd2);
    drain("s4");

    // Clear together with an in-window store.
    trc_ready = 1'b0;
    put(32'h190, 32'h11111111, 4'hF);
    clr = 1'b1; mem_we = 1'b1; mem_addr = 32'h194; mem_wdata = 32'h22222222;
    tick();
    clr = 1'b0; mem_we = 1'b0;
    chk("clr_valid", trc_valid, 1'b0);
    chk("clr_hit0", hit_cnt[CW-1:0], 6'd0);
    chk("clr_drop", drop_cnt, 6'd0);
    tick();
    chk("clr_valid2", trc_valid, 1'b0);
    trc_ready = 1'b1;
    put(32'h184, 32'hA5A5A5A5, 4'h1);
    chk("clr_time", trc_time, 32'h1);
    drain("clr");
    chk_cnt("clr");

`ifdef TRACE_SIG_EN
    pulse_clr();
    put(32'h180, 32'h1, 4'hF);
    chk("sig_a", sig[31:0], 32'h1);
    put(32'h184, 32'h2, 4'hF);
    chk("sig_b", sig[31:0], 32'h1);
    drain("sig");
`endif

    // Window wrapping the top of the address space.
    words[0] = '0;
    base[1] = 30'h3FFFFFFE; words[1] = 30'd4;
    put(32'h4, 32'h55, 4'hF);
    chk("wrap_win", trc_win, 1'b1);
    chk("wrap_off", trc_off, 30'h3);
    put(32'hFFFFFFF8, 32'h66, 4'hC);
    put(32'h8, 32'h77, 4'hF);
    drain("wrap");
    chk_cnt("wrap");

    // Random traffic with random back-pressure.
    base[0] = 30'h10; words[0] = 30'd8;
    base[1] = 30'h14; words[1] = 30'd8;
    for (int i = 0; i < 300; i++) begin
      mem_we    = 1'($urandom_range(0, 1));
      mem_addr  = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
      mem_wdata = $urandom;
      mem_wstrb = 4'($urandom);
      trc_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    mem_we = 1'b0;
    drain("rand");
    chk_cnt("rand");

    // Counter saturation, then reset mid-stream.
    pulse_clr();
    trc_ready = 1'b0;
    base[0] = 30'h60; words[0] = 30'd32;
    for (int i = 0; i < 90; i++) put(32'h180 + 32'(4 * (i % 32)), 32'(i), 4'hF);
    chk("sat_hit0", hit_cnt[CW-1:0], 6'h3F);
    chk("sat_drop", drop_cnt, 6'h3F);
    chk_cnt("sat");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", trc_valid, 1'b0);
    chk("rst2_data", trc_data, 32'h0);
    chk_cnt("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
